// File: rtl/simd_pkg.sv
// Shared widths and types for the 128-bit SIMD datapath
// (pipeline registers, forwarding mux, register file).
package simd_pkg;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 5;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/ex_wb_fwd_stage_if.sv
// Bundle between the EX/WB stage and its neighbours: EX inputs, decode
// source indices, forwarding selects/data, register-file write port, counter.
interface ex_wb_fwd_stage_if
  import simd_pkg::*;
#(
  parameter int CNT_W = 32
) ();
  logic             stall;
  logic             flush;
  logic             ex_valid;
  logic             ex_wen;
  reg_addr_t        ex_rd;
  data_t            ex_result;
  reg_addr_t        id_rs1_addr;
  reg_addr_t        id_rs2_addr;
  reg_addr_t        id_rs3_addr;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             id_rs3_used;
  logic             s1;
  logic             s2;
  logic             s3;
  data_t            data;
  logic             wb_wen;
  reg_addr_t        wb_addr;
  data_t            wb_data;
  logic [CNT_W-1:0] fwd_count;

  modport master (
    output stall, flush, ex_valid, ex_wen, ex_rd, ex_result,
    output id_rs1_addr, id_rs2_addr, id_rs3_addr,
    output id_rs1_used, id_rs2_used, id_rs3_used,
    input  s1, s2, s3, data, wb_wen, wb_addr, wb_data, fwd_count
  );

  modport slave (
    input  stall, flush, ex_valid, ex_wen, ex_rd, ex_result,
    input  id_rs1_addr, id_rs2_addr, id_rs3_addr,
    input  id_rs1_used, id_rs2_used, id_rs3_used,
    output s1, s2, s3, data, wb_wen, wb_addr, wb_data, fwd_count
  );
endinterface

// File: rtl/ex_wb_fwd_stage_fwd_cmp.sv
// Single-source forwarding comparator: selects the WB value when the
// pending write targets the register this source operand reads.
module fwd_cmp
  import simd_pkg::*;
(
  input  logic      i_wb_wen,
  input  reg_addr_t i_wb_addr,
  input  reg_addr_t i_rs_addr,
  input  logic      i_rs_used,
  output logic      o_sel
);
  assign o_sel = i_wb_wen & i_rs_used & (i_wb_addr == i_rs_addr);
endmodule

// File: rtl/ex_wb_fwd_stage.sv
// EX/WB pipeline register with operand-forwarding selects and a
// saturating count of cycles in which any forward was taken.
module ex_wb_fwd_stage
  import simd_pkg::*;
#(
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  ex_wb_fwd_stage_if.slave  bus
);
  logic             r_wb_wen;
  reg_addr_t        r_wb_addr;
  data_t            r_wb_data;
  logic [CNT_W-1:0] r_fwd_count;

  logic             w_load_wen;
  logic             w_rd_is_zero;
  reg_addr_t        w_rs_addr [3];
  logic             w_rs_used [3];
  logic             w_sel     [3];
  logic             w_any_sel;

  // Register 0 is never written when hard-wired, so it can never be forwarded either.
  assign w_rd_is_zero = (ZERO_REG != 0) && (bus.ex_rd == '0);
  assign w_load_wen   = bus.ex_valid & bus.ex_wen & ~w_rd_is_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_wen  <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else if (bus.flush) begin
      r_wb_wen  <= 1'b0;
    end else if (!bus.stall) begin
      r_wb_wen  <= w_load_wen;
      r_wb_addr <= bus.ex_rd;
      r_wb_data <= bus.ex_result;
    end
  end

  assign w_rs_addr[0] = bus.id_rs1_addr;
  assign w_rs_addr[1] = bus.id_rs2_addr;
  assign w_rs_addr[2] = bus.id_rs3_addr;
  assign w_rs_used[0] = bus.id_rs1_used;
  assign w_rs_used[1] = bus.id_rs2_used;
  assign w_rs_used[2] = bus.id_rs3_used;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cmp
      fwd_cmp u_cmp (
        .i_wb_wen  (r_wb_wen),
        .i_wb_addr (r_wb_addr),
        .i_rs_addr (w_rs_addr[gi]),
        .i_rs_used (w_rs_used[gi]),
        .o_sel     (w_sel[gi])
      );
    end
  endgenerate

  assign w_any_sel = w_sel[0] | w_sel[1] | w_sel[2];

  // Stall does not gate counting: a held WB value still feeds decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_count <= '0;
    end else if (w_any_sel && (r_fwd_count != '1)) begin
      r_fwd_count <= r_fwd_count + 1'b1;
    end
  end

  assign bus.s1        = w_sel[0];
  assign bus.s2        = w_sel[1];
  assign bus.s3        = w_sel[2];
  assign bus.data      = r_wb_data;
  assign bus.wb_wen    = r_wb_wen;
  assign bus.wb_addr   = r_wb_addr;
  assign bus.wb_data   = r_wb_data;
  assign bus.fwd_count = r_fwd_count;
endmodule

// File: tb/tb_ex_wb_fwd_stage.sv
// Drives two stage instances (hard-wired r0 / 32-bit counter and writable r0 /
// 4-bit counter) with identical stimulus and compares both against a reference model.
module tb_ex_wb_fwd_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         stall, flush, ex_valid, ex_wen;
  logic [4:0]   ex_rd;
  logic [127:0] ex_result;
  logic [4:0]   rs_addr [3];
  logic         rs_used [3];

  ex_wb_fwd_stage_if #(.CNT_W(32)) if0 ();
  ex_wb_fwd_stage_if #(.CNT_W(4))  if1 ();

  ex_wb_fwd_stage #(.ZERO_REG(1), .CNT_W(32)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  ex_wb_fwd_stage #(.ZERO_REG(0), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  assign if0.stall = stall;        assign if1.stall = stall;
  assign if0.flush = flush;        assign if1.flush = flush;
  assign if0.ex_valid = ex_valid;  assign if1.ex_valid = ex_valid;
  assign if0.ex_wen = ex_wen;      assign if1.ex_wen = ex_wen;
  assign if0.ex_rd = ex_rd;        assign if1.ex_rd = ex_rd;
  assign if0.ex_result = ex_result; assign if1.ex_result = ex_result;
  assign if0.id_rs1_addr = rs_addr[0]; assign if1.id_rs1_addr = rs_addr[0];
  assign if0.id_rs2_addr = rs_addr[1]; assign if1.id_rs2_addr = rs_addr[1];
  assign if0.id_rs3_addr = rs_addr[2]; assign if1.id_rs3_addr = rs_addr[2];
  assign if0.id_rs1_used = rs_used[0]; assign if1.id_rs1_used = rs_used[0];
  assign if0.id_rs2_used = rs_used[1]; assign if1.id_rs2_used = rs_used[1];
  assign if0.id_rs3_used = rs_used[2]; assign if1.id_rs3_used = rs_used[2];

  logic         d_wen    [2];
  logic [4:0]   d_addr   [2];
  logic [127:0] d_wbdata [2];
  logic [127:0] d_data   [2];
  logic         d_s      [2][3];
  logic [31:0]  d_cnt    [2];

  assign d_wen[0] = if0.wb_wen;       assign d_wen[1] = if1.wb_wen;
  assign d_addr[0] = if0.wb_addr;     assign d_addr[1] = if1.wb_addr;
  assign d_wbdata[0] = if0.wb_data;   assign d_wbdata[1] = if1.wb_data;
  assign d_data[0] = if0.data;        assign d_data[1] = if1.data;
  assign d_s[0][0] = if0.s1; assign d_s[0][1] = if0.s2; assign d_s[0][2] = if0.s3;
  assign d_s[1][0] = if1.s1; assign d_s[1][1] = if1.s2; assign d_s[1][2] = if1.s3;
  assign d_cnt[0] = if0.fwd_count;
  assign d_cnt[1] = {28'd0, if1.fwd_count};

  // Reference model: architectural WB contents and forward counter per instance.
  logic         m_wen  [2];
  logic [4:0]   m_addr [2];
  logic [127:0] m_data [2];
  logic [31:0]  m_cnt  [2];
  logic [31:0]  m_cmax [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic exp_sel(input int k, input int n);
    return m_wen[k] && rs_used[n] && (m_addr[k] == rs_addr[n]);
  endfunction

  task automatic step();
    logic any_hit [2];
    for (int k = 0; k < 2; k++)
      any_hit[k] = exp_sel(k, 0) || exp_sel(k, 1) || exp_sel(k, 2);
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_wen[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0; m_cnt[k] = '0;
      end else begin
        if (any_hit[k] && m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        if (flush) begin
          m_wen[k] = 1'b0;
        end else if (!stall) begin
          m_wen[k]  = ex_valid && ex_wen && !(k == 0 && ex_rd == 5'd0);
          m_addr[k] = ex_rd;
          m_data[k] = ex_result;
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d.wb_wen", k),  {127'd0, d_wen[k]}, {127'd0, m_wen[k]});
      chk($sformatf("d%0d.wb_addr", k), {123'd0, d_addr[k]}, {123'd0, m_addr[k]});
      chk($sformatf("d%0d.wb_data", k), d_wbdata[k], m_data[k]);
      chk($sformatf("d%0d.data", k),    d_data[k], m_data[k]);
      for (int n = 0; n < 3; n++)
        chk($sformatf("d%0d.s%0d", k, n + 1), {127'd0, d_s[k][n]}, {127'd0, exp_sel(k, n)});
      chk($sformatf("d%0d.fwd_count", k), {96'd0, d_cnt[k]}, {96'd0, m_cnt[k]});
    end
    $display("[TB] cyc %0d rst=%0b fl=%0b st=%0b ex=%0b/%0b rd=%0d | wen=%0b addr=%0d s=%0b%0b%0b cnt=%0d/%0d",
             cyc, rst, flush, stall, ex_valid, ex_wen, ex_rd, d_wen[0], d_addr[0],
             d_s[0][0], d_s[0][1], d_s[0][2], d_cnt[0], d_cnt[1]);
  endtask

  task automatic set_rs(input logic [4:0] a0, a1, a2, input logic u0, u1, u2);
    rs_addr[0] = a0; rs_addr[1] = a1; rs_addr[2] = a2;
    rs_used[0] = u0; rs_used[1] = u1; rs_used[2] = u2;
  endtask

  initial begin
    m_cmax[0] = 32'hFFFF_FFFF;
    m_cmax[1] = 32'd15;
    for (int k = 0; k < 2; k++) begin
      m_wen[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0; m_cnt[k] = '0;
    end
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    ex_valid = 1'b1; ex_wen = 1'b1; ex_rd = 5'd3; ex_result = 128'h1234;
    set_rs(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1);

    // Reset held for two cycles with a live writing instruction in EX
    step(); step();
    chk("rst.wb_wen", {127'd0, d_wen[0]}, 128'd0);
    chk("rst.wb_data", d_wbdata[0], 128'd0);
    chk("rst.s1", {127'd0, d_s[0][0]}, 128'd0);
    chk("rst.fwd_count", {96'd0, d_cnt[0]}, 128'd0);

    // Basic forward on source 2
    rst = 1'b0; ex_rd = 5'd7; ex_result = 128'hDEAD_BEEF;
    set_rs(5'd1, 5'd7, 5'd2, 1'b0, 1'b1, 1'b0);
    step();
    chk("fwd.s2", {127'd0, d_s[0][1]}, 128'd1);
    chk("fwd.s1", {127'd0, d_s[0][0]}, 128'd0);
    chk("fwd.data", d_data[0], 128'hDEAD_BEEF);
    chk("fwd.wb_addr", {123'd0, d_addr[0]}, 128'd7);
    ex_valid = 1'b0;
    step();
    chk("fwd.count1", {96'd0, d_cnt[0]}, 128'd1);

    // Same destination on all three sources, third unused
    ex_valid = 1'b1; ex_rd = 5'd9; ex_result = 128'hABCD;
    set_rs(5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
    step();
    chk("tri.s1", {127'd0, d_s[0][0]}, 128'd1);
    chk("tri.s2", {127'd0, d_s[0][1]}, 128'd1);
    chk("tri.s3", {127'd0, d_s[0][2]}, 128'd0);

    // Writes to register 0: dropped when hard-wired, forwarded otherwise
    ex_rd = 5'd0; ex_result = 128'h5555;
    set_rs(5'd0, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk("zr1.wb_wen", {127'd0, d_wen[0]}, 128'd0);
    chk("zr1.s1", {127'd0, d_s[0][0]}, 128'd0);
    chk("zr0.wb_wen", {127'd0, d_wen[1]}, 128'd1);
    chk("zr0.s1", {127'd0, d_s[1][0]}, 128'd1);

    // Stall holds WB while EX moves on; flush+stall leaves a bubble
    ex_rd = 5'd4; ex_result = 128'hAAAA_0000_AAAA;
    set_rs(5'd2, 5'd2, 5'd2, 1'b0, 1'b0, 1'b0);
    step();
    stall = 1'b1; ex_rd = 5'd5; ex_result = 128'hBBBB;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.wb_addr", {123'd0, d_addr[0]}, 128'd4);
      chk("stall.data", d_data[0], 128'hAAAA_0000_AAAA);
    end
    flush = 1'b1;
    set_rs(5'd4, 5'd4, 5'd4, 1'b1, 1'b1, 1'b1);
    step();
    chk("flush.wb_wen", {127'd0, d_wen[0]}, 128'd0);
    chk("flush.s_any", {125'd0, d_s[0][0], d_s[0][1], d_s[0][2]}, 128'd0);
    flush = 1'b0; stall = 1'b0;

    // Counter saturation on the 4-bit instance
    rst = 1'b1;
    step();
    rst = 1'b0; ex_rd = 5'd1; ex_result = 128'h77;
    set_rs(5'd1, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
    step();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat.cnt4", {96'd0, d_cnt[1]}, 128'd15);
    chk("sat.cnt32", {96'd0, d_cnt[0]}, 128'd20);
    stall = 1'b0;

    // Randomized traffic over a small register window to provoke hits and r0
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      ex_valid  = ($urandom_range(0, 4) != 0);
      ex_wen    = ($urandom_range(0, 3) != 0);
      ex_rd     = 5'($urandom_range(0, 3));
      ex_result = {$urandom, $urandom, $urandom, $urandom};
      set_rs(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_wb_fwd_stage.md
Name: ex_wb_fwd_stage

Overview:
- EX/WB pipeline register of the 128-bit SIMD datapath, paired with the operand-forwarding select logic.
- Registers the EX-stage result, destination index and write enable, and drives the register-file write port.
- Compares the registered destination against the three source indices of the instruction in decode.
- Produces s1/s2/s3 and the 128-bit data word for the downstream operand-forwarding mux (inputs s1..s3, data).

Parameters:
- DATA_W, 128, SIMD register width
- ADDR_W, 5, register index width (32 registers)
- ZERO_REG, 1, when 1 register 0 is hard-wired: writes to it are dropped and never forwarded
- CNT_W, 32, width of the forwarding-event counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active high
- stall  in  1  hold WB register contents
- flush  in  1  replace WB contents with a bubble
- ex_valid  in  1  EX stage holds a real instruction
- ex_wen  in  1  EX instruction writes a register
- ex_rd  in  ADDR_W  EX destination index
- ex_result  in  DATA_W  EX 128-bit result
- id_rs1_addr, id_rs2_addr, id_rs3_addr  in  ADDR_W each  decode source indices
- id_rs1_used, id_rs2_used, id_rs3_used  in  1 each  source operand is actually read
- s1, s2, s3  out  1 each  forward select to the forwarding mux
- data  out  DATA_W  forwarded value (equals wb_data)
- wb_wen  out  1  register-file write enable
- wb_addr  out  ADDR_W  register-file write index
- wb_data  out  DATA_W  register-file write data
- fwd_count  out  CNT_W  cycles in which any select was asserted

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at an edge): wb_valid=0, wb_wen=0, wb_addr=0, wb_data=0, fwd_count=0.
  - s1..s3 are therefore 0 in the cycle after reset.
  - rst overrides flush and stall.
  - Reset mid-operation discards the in-flight result; no write is issued.
- Edge priority: rst > flush > stall > load.
  - flush: wb_valid<=0, wb_wen<=0; wb_addr and wb_data hold.
  - stall (no flush): all WB state holds. wb_wen stays as is, so the repeated write is idempotent.
  - load: wb_valid<=ex_valid.
  - load: wb_wen<=ex_valid & ex_wen & ~(ZERO_REG & ex_rd==0).
  - load: wb_addr<=ex_rd, wb_data<=ex_result.
- Latency: EX inputs appear on wb_* and data exactly 1 cycle later.
- Selects are combinational from registered WB state and current decode inputs. For n = 1..3: sn = wb_wen & id_rsn_used & (wb_addr == id_rsn_addr).
- Any number of s1..s3 may be high simultaneously; all receive the same data.
- data = wb_data unconditionally. Its value is don't-care when all selects are 0 but must not be X after reset.
- fwd_count increments by 1 at each edge where (s1|s2|s3)=1 and rst=0.
  - Counts during stall cycles too.
  - Saturates at all-ones (no wrap).
- No arithmetic on data; widths pass through unmodified.

Decomposition:
- Package simd_pkg holds DATA_W, ADDR_W, and the typedefs for data (logic [DATA_W-1:0]) and reg_addr (logic [ADDR_W-1:0]), shared with the forwarding mux and register file.
- One natural sub-module, fwd_cmp: a single-source comparator (wb_wen, wb_addr, rs_addr, rs_used -> sel), instantiated three times.
- The top level holds the pipeline register and the saturating counter.

Test Plan:
- Reset: drive rst for 2 cycles with ex_valid=1, ex_wen=1, ex_rd=3 -> after release, wb_wen=0, s1..s3=0, wb_data=0, fwd_count=0.
- Basic forward: ex_rd=7, ex_wen=1, ex_result=128'hDEAD_BEEF; next cycle id_rs2_addr=7, id_rs2_used=1 -> s2=1, s1=s3=0, data=wb_data=128'hDEAD_BEEF, wb_addr=7, fwd_count becomes 1.
- Triple hit and unused source: all three rs_addr=9 with used=1,1,0 and WB rd=9 -> s1=1, s2=1, s3=0.
- Zero register: ex_rd=0, ex_wen=1, ZERO_REG=1; next cycle id_rs1_addr=0, used=1 -> wb_wen=0, s1=0. With ZERO_REG=0 -> wb_wen=1, s1=1.
- Stall/flush: load rd=4, val=A; stall 3 cycles while EX presents rd=5 -> wb_addr stays 4, data stays A. Assert flush and stall together -> next cycle wb_wen=0 and every select is 0.
- Counter saturation: CNT_W=4, keep s1 asserted for 20 cycles -> fwd_count reaches 15 and holds.
